mau_load: RTL and testbench
===========================

Name: mau_load

Overview:
- Load path of the memory access unit (MAU).
- Accepts one load request at a time from the execute stage and runs a single AHB-lite read on the data bus.
- Aligns and sign- or zero-extends the returned data.
- Drives the mau_load_rd / mau_load_data / mau_load_en triple consumed by the write-back unit (wbu_swc). It is the producer end of that interface.

Parameters:
- ADDR_W, 32, bus and request address width
- DATA_W, 32, bus data width and mau_load_data width (fixed at 32; byte lanes assume 4 bytes)

Ports:
- hclk  input  1  clock
- hrst  input  1  asynchronous active-high reset
- req_valid  input  1  load request valid
- req_ready  output  1  unit can accept a request
- req_rd  input  5  destination register
- req_addr  input  ADDR_W  byte address
- req_funct3  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- haddr  output  ADDR_W  AHB address
- htrans  output  2  AHB transfer type: 00 IDLE, 10 NONSEQ
- hsize  output  3  000 byte, 001 half, 010 word
- hwrite  output  1  tied 0
- hready  input  1  AHB ready
- hrdata  input  DATA_W  AHB read data
- hresp  input  1  AHB error
- mau_load_rd  output  5  write-back destination
- mau_load_data  output  DATA_W  extended load data
- mau_load_en  output  1  write-back strobe, one-cycle pulse
- load_err  output  1  misalign or bus error, one-cycle pulse

Behaviour:
- Reset: hclk single clock domain; hrst asynchronous active-high.
  - While reset is asserted: state=IDLE; req_ready=1; htrans=00; haddr=0; hsize=0; mau_load_rd=0; mau_load_data=0; mau_load_en=0; load_err=0.
  - Reset mid-transaction abandons the bus access; no write-back and no error pulse follow.
- FSM states: IDLE, ADDR, DATA.
- IDLE: req_ready=1. On req_valid, latch rd, addr and funct3.
  - Illegal request (funct3 not in the legal set, lh/lhu with addr[0]=1, or lw with addr[1:0]!=0): pulse load_err next cycle, stay IDLE, no bus access.
  - Legal request: go to ADDR.
- ADDR: htrans=10; haddr=latched addr (byte-exact); hsize from funct3. When hready=1, go to DATA. If hready=0, hold all bus outputs stable.
- DATA: htrans=00.
  - Wait until hready=1, then sample hrdata/hresp and return to IDLE.
  - hresp=1: pulse load_err; mau_load_en stays 0.
  - Otherwise: register the result and pulse mau_load_en for exactly one cycle.
- Data extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw passes through.
- Write-back and error outputs:
  - rd=0: bus read completes, but mau_load_en is suppressed.
  - mau_load_rd and mau_load_data hold their last value when mau_load_en=0.
  - mau_load_en and load_err are never high together.
- Latency with zero wait states:
  - accept at cycle T; ADDR at T+1; DATA sampled at T+2; mau_load_en high at T+3.
  - Each hready=0 cycle adds one cycle.
- Back-to-back: req_ready returns to 1 in the cycle after DATA completes. There is no overlap of transfers and no pipelining.

Decomposition:
- Shared package mau_pkg:
  - funct3 load codes
  - HTRANS_IDLE / HTRANS_NONSEQ
  - HSIZE codes
  - FSM state enum
- Sub-module mau_load_align: combinational extract/extend from (hrdata, addr[1:0], funct3) to 32-bit result.

Test Plan:
- lw addr=0x100, hrdata=0xDEADBEEF, hready=1: htrans=10 at T+1; mau_load_en=1, mau_load_rd=req_rd, mau_load_data=0xDEADBEEF at T+3, for one cycle.
- lb addr=0x103, hrdata=0x80112233: data=0xFFFFFF80. lbu same: 0x00000080. lhu addr=0x102: 0x00008011.
- lh addr=0x101: load_err pulses at T+1; htrans stays 00; mau_load_en=0; req_ready=1 throughout.
- lw with hready=0 for 3 cycles in DATA, then hresp=1: haddr/hsize stable; load_err=1 one cycle; no mau_load_en.
- lw rd=0: bus transfer occurs; mau_load_en stays 0. Next request accepted the cycle after completion.
- hrst asserted during DATA: outputs reset immediately. After release, a new lw completes normally with no stale mau_load_en.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared constants, state encoding and load-decode helpers for the MAU load path.
package mau_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } mau_state_e;

  function automatic logic [2:0] hsize_of(input logic [2:0] f3);
    logic [2:0] sz;
    case (f3)
      F3_LH, F3_LHU: sz = HSIZE_HALF;
      F3_LW:         sz = HSIZE_WORD;
      default:       sz = HSIZE_BYTE;
    endcase
    return sz;
  endfunction

  // A request is legal only for a known load code at a naturally aligned address.
  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic ok;
    case (f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~addr_lo[0];
      F3_LW:         ok = (addr_lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Picks the addressed byte/half lane out of a 32-bit read word and extends it.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] hrdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = hrdata[7:0];
      2'd1:    byte_v = hrdata[15:8];
      2'd2:    byte_v = hrdata[23:16];
      default: byte_v = hrdata[31:24];
    endcase
    half_v = addr_lo[1] ? hrdata[31:16] : hrdata[15:0];

    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  result = {24'd0, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LHU:  result = {16'd0, half_v};
      default: result = hrdata;
    endcase
  end

endmodule

// File: rtl/mau_load.sv
// MAU load path: one AHB-lite read per request, then aligned write-back or error pulse.
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
module mau_load
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic              hwrite,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp,
  output logic [4:0]        mau_load_rd,
  output logic [DATA_W-1:0] mau_load_data,
  output logic              mau_load_en,
  output logic              load_err
);

  mau_state_e        state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_en_q, wb_en_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] aligned;

  mau_load_align u_align (
    .hrdata  (hrdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (aligned)
  );

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_en_d   = 1'b0;
    err_d     = 1'b0;
    req_ready = 1'b0;
    htrans    = HTRANS_IDLE;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rd_d   = req_rd;
          addr_d = req_addr;
          f3_d   = req_funct3;
          if (load_legal(req_funct3, req_addr[1:0])) state_d = ST_ADDR;
          else                                       err_d   = 1'b1;
        end
      end
      ST_ADDR: begin
        htrans = HTRANS_NONSEQ;
        if (hready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (hready) begin
          state_d = ST_IDLE;
          if (hresp) begin
            err_d = 1'b1;
          end else if (rd_q != 5'd0) begin
            // x0 loads still run on the bus but never reach write-back.
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = aligned;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address-phase outputs come straight from latched request fields, so they stay stable under wait states.
  assign haddr         = addr_q;
  assign hsize         = hsize_of(f3_q);
  assign hwrite        = 1'b0;
  assign mau_load_rd   = wb_rd_q;
  assign mau_load_data = wb_data_q;
  assign mau_load_en   = wb_en_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_mau_load.sv
// Randomized scoreboard bench for mau_load with an in-bench AHB slave and reference model.
module tb_mau_load;

  logic        hclk;
  logic        hrst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic [4:0]  mau_load_rd;
  logic [31:0] mau_load_data;
  logic        mau_load_en;
  logic        load_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  // {is_err, rd, data}
  logic [37:0] exp_q[$];
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  mau_load #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk          (hclk),
    .hrst          (hrst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rd        (req_rd),
    .req_addr      (req_addr),
    .req_funct3    (req_funct3),
    .haddr         (haddr),
    .htrans        (htrans),
    .hsize         (hsize),
    .hwrite        (hwrite),
    .hready        (hready),
    .hrdata        (hrdata),
    .hresp         (hresp),
    .mau_load_rd   (mau_load_rd),
    .mau_load_data (mau_load_data),
    .mau_load_en   (mau_load_en),
    .load_err      (load_err)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // reference model
  function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) == 0;
    if (f3 == 3'd2) return (addr % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [2:0] ref_hsize(input logic [2:0] f3);
    if (f3 == 3'd2) return 3'd2;
    if (f3 == 3'd1 || f3 == 3'd5) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    longint w = longint'(word);
    longint v;
    int off = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (off / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  // driver: issues one request and plays the AHB slave for it
  task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                         input int aw, input int dw, input bit err, input logic [31:0] data);
    bit legal = ref_legal(f3, addr);
    if (!legal || err) exp_q.push_back({1'b1, rd, 32'd0});
    else if (rd != 5'd0) exp_q.push_back({1'b0, rd, ref_data(f3, addr, data)});

    @(negedge hclk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_rd     = rd;
    req_addr   = addr;
    req_funct3 = f3;
    @(posedge hclk);
    @(negedge hclk);
    req_valid = 1'b0;
    if (!legal) begin
      check("illegal_err", {31'd0, load_err}, 32'd1);
      check("illegal_htrans", {30'd0, htrans}, 32'd0);
      check("illegal_ready", {31'd0, req_ready}, 32'd1);
      return;
    end
    for (int i = 0; i < aw; i++) begin
      check("addr_wait_htrans", {30'd0, htrans}, 32'd2);
      check("addr_wait_haddr", haddr, addr);
      hready = 1'b0;
      @(posedge hclk);
      @(negedge hclk);
    end
    check("addr_htrans", {30'd0, htrans}, 32'd2);
    check("addr_haddr", haddr, addr);
    check("addr_hsize", {29'd0, hsize}, {29'd0, ref_hsize(f3)});
    check("addr_hwrite", {31'd0, hwrite}, 32'd0);
    hready = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    check("data_htrans", {30'd0, htrans}, 32'd0);
    for (int i = 0; i < dw; i++) begin
      hready = 1'b0;
      @(posedge hclk);
      @(negedge hclk);
      check("data_wait_htrans", {30'd0, htrans}, 32'd0);
      check("data_wait_haddr", haddr, addr);
      check("data_wait_hsize", {29'd0, hsize}, {29'd0, ref_hsize(f3)});
      check("data_wait_no_en", {31'd0, mau_load_en}, 32'd0);
    end
    hready = 1'b1;
    hrdata = data;
    hresp  = err;
    @(posedge hclk);
    @(negedge hclk);
    check("wb_en_latency", {31'd0, mau_load_en}, {31'd0, !err && rd != 5'd0});
    check("wb_err_latency", {31'd0, load_err}, {31'd0, err});
    check("ready_after", {31'd0, req_ready}, 32'd1);
    hresp  = 1'b0;
    hrdata = $urandom;
  endtask

  // monitor / scoreboard
  always @(negedge hclk) begin
    if (hrst) begin
      last_rd   = 5'd0;
      last_data = 32'd0;
    end else begin
      if (mau_load_en && load_err) check("en_err_exclusive", 32'd1, 32'd0);
      if (mau_load_en || load_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, mau_load_en, load_err}, 32'd0);
        end else begin
          logic [37:0] e;
          e = exp_q.pop_front();
          if (e[37]) begin
            check("sb_err", {31'd0, load_err}, 32'd1);
          end else begin
            check("sb_en", {31'd0, mau_load_en}, 32'd1);
            check("sb_rd", {27'd0, mau_load_rd}, {27'd0, e[36:32]});
            check("sb_data", mau_load_data, e[31:0]);
            last_rd   = e[36:32];
            last_data = e[31:0];
          end
        end
      end
      if (!mau_load_en) begin
        check("hold_rd", {27'd0, mau_load_rd}, {27'd0, last_rd});
        check("hold_data", mau_load_data, last_data);
      end
    end
  end

  initial begin
    hrst = 1'b1;
    req_valid = 1'b0;
    req_rd = '0;
    req_addr = '0;
    req_funct3 = '0;
    hready = 1'b1;
    hrdata = '0;
    hresp = 1'b0;
    repeat (2) @(negedge hclk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_htrans", {30'd0, htrans}, 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hsize", {29'd0, hsize}, 32'd0);
    check("rst_rd", {27'd0, mau_load_rd}, 32'd0);
    check("rst_data", mau_load_data, 32'd0);
    check("rst_en_err", {30'd0, mau_load_en, load_err}, 32'd0);
    hrst = 1'b0;

    // directed cases
    do_load(5'd5,  32'h100, 3'b010, 0, 0, 1'b0, 32'hDEADBEEF);
    do_load(5'd6,  32'h103, 3'b000, 0, 0, 1'b0, 32'h80112233);
    do_load(5'd7,  32'h103, 3'b100, 0, 0, 1'b0, 32'h80112233);
    do_load(5'd8,  32'h102, 3'b101, 0, 0, 1'b0, 32'h80112233);
    do_load(5'd9,  32'h102, 3'b001, 1, 0, 1'b0, 32'h80112233);
    do_load(5'd10, 32'h101, 3'b001, 0, 0, 1'b0, 32'h12345678);
    do_load(5'd11, 32'h102, 3'b010, 0, 0, 1'b0, 32'h12345678);
    do_load(5'd12, 32'h104, 3'b011, 0, 0, 1'b0, 32'h12345678);
    do_load(5'd13, 32'h108, 3'b010, 2, 3, 1'b1, 32'hCAFEF00D);
    do_load(5'd0,  32'h10C, 3'b010, 0, 0, 1'b0, 32'h55AA55AA);
    do_load(5'd14, 32'h110, 3'b010, 0, 0, 1'b0, 32'h01020304);

    // reset in the data phase abandons the access
    @(negedge hclk);
    req_valid = 1'b1; req_rd = 5'd20; req_addr = 32'h200; req_funct3 = 3'b010;
    @(posedge hclk);
    @(negedge hclk);
    req_valid = 1'b0;
    hready = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    hready = 1'b0;
    hrst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_htrans", {30'd0, htrans}, 32'd0);
    check("midrst_haddr", haddr, 32'd0);
    check("midrst_rd", {27'd0, mau_load_rd}, 32'd0);
    check("midrst_data", mau_load_data, 32'd0);
    check("midrst_en_err", {30'd0, mau_load_en, load_err}, 32'd0);
    @(negedge hclk);
    hrst = 1'b0;
    hready = 1'b1;
    hrdata = 32'hFFFF0000;
    repeat (3) @(negedge hclk);
    do_load(5'd21, 32'h204, 3'b010, 0, 0, 1'b0, 32'hA5A5A5A5);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      do_load(5'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 7) == 0), $urandom);
    end

    repeat (4) @(negedge hclk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
